// File: rtl/device_bus_initiator.sv
`default_nettype none
// ============================================================================
// device_bus_initiator : core-side initiator for the device register bus.
// Revision 1.0
// ============================================================================
module device_bus_initiator #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEV_SEL_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [DEV_SEL_WIDTH+ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  output logic                                rsp_valid,
  output logic                                rsp_write,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [ADDR_WIDTH-1:0]               bus_address,
  output logic [(1<<DEV_SEL_WIDTH)-1:0]       bus_enable,
  output logic                                bus_mode,
  output logic [DATA_WIDTH-1:0]               bus_data_out,
  input  logic [DATA_WIDTH-1:0]               bus_data_in
);

  localparam int NUM_DEVICES = 1 << DEV_SEL_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0]    bus_address_q, bus_address_d;
  logic [NUM_DEVICES-1:0]   bus_enable_q, bus_enable_d;
  logic                     bus_mode_q, bus_mode_d;
  logic [DATA_WIDTH-1:0]    bus_data_out_q, bus_data_out_d;
  logic [DEV_SEL_WIDTH-1:0] dev_sel;

  assign dev_sel = req_addr[DEV_SEL_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];

  always_comb begin
    state_d        = state_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_write_d    = rsp_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    bus_address_d  = bus_address_q;
    bus_enable_d   = bus_enable_q;
    bus_mode_d     = bus_mode_q;
    bus_data_out_d = bus_data_out_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          bus_address_d         = req_addr[ADDR_WIDTH-1:0];
          bus_enable_d          = '0;
          bus_enable_d[dev_sel] = 1'b1;
          bus_mode_d            = ~req_write;
          if (req_write) begin
            bus_data_out_d = req_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // bus_mode still carries the access type until this edge
        rsp_valid_d  = 1'b1;
        rsp_write_d  = ~bus_mode_q;
        rsp_rdata_d  = bus_mode_q ? bus_data_in : '0;
        bus_enable_d = '0;
        bus_mode_d   = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      bus_address_q  <= '0;
      bus_enable_q   <= '0;
      bus_mode_q     <= 1'b1;
      bus_data_out_q <= '0;
    end else begin
      state_q        <= state_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      bus_address_q  <= bus_address_d;
      bus_enable_q   <= bus_enable_d;
      bus_mode_q     <= bus_mode_d;
      bus_data_out_q <= bus_data_out_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign bus_address  = bus_address_q;
  assign bus_enable   = bus_enable_q;
  assign bus_mode     = bus_mode_q;
  assign bus_data_out = bus_data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_device_bus_initiator.sv
`default_nettype none
// ============================================================================
// tb_device_bus_initiator : randomized bench with timeline reference model.
// Revision 1.0
// ============================================================================
module tb_device_bus_initiator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [5:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic [3:0] bus_address;
  logic [3:0] bus_enable;
  logic       bus_mode;
  logic [7:0] bus_data_out;
  logic [7:0] bus_data_in;

  device_bus_initiator #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .DEV_SEL_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .bus_address(bus_address), .bus_enable(bus_enable), .bus_mode(bus_mode),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
  );

  always #5 clk = ~clk;

  // Register-bank devices: write on falling edge, drive read data while enabled.
  logic [7:0] dev_mem [4][16] = '{default: '{default: 8'h00}};

  always @(negedge clk) begin
    if (!bus_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_enable[i]) dev_mem[i][bus_address] <= bus_data_out;
      end
    end
  end

  always_comb begin
    bus_data_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (bus_mode && bus_enable[i]) bus_data_in = dev_mem[i][bus_address];
    end
  end

  // Reference model: shadow register contents plus position in the access timeline.
  logic [7:0] shadow [4][16] = '{default: '{default: 8'h00}};
  int         age = -1;       // -1 idle, 0 first cycle after accept, 1 second cycle
  int         now = 0;
  bit         acc_w;
  logic [7:0] acc_rdata;
  logic       e_ready = 1'b1, e_rv = 1'b0, e_rw = 1'b0, e_mode = 1'b1;
  logic [7:0] e_rd = '0, e_dout = '0;
  logic [3:0] e_addr = '0, e_en = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int sel;
    int ra;
    now++;
    if (reset) begin
      age = -1; e_ready = 1; e_rv = 0; e_rw = 0; e_rd = 0;
      e_en = 0; e_mode = 1; e_addr = 0; e_dout = 0;
    end else if (age == -1) begin
      if (req_valid) begin
        sel    = int'(req_addr[5:4]);
        ra     = int'(req_addr[3:0]);
        age    = 0;
        acc_w  = req_write;
        e_ready = 0;
        e_addr = req_addr[3:0];
        e_en   = 4'(1 << sel);
        e_mode = !req_write;
        if (req_write) begin
          e_dout = req_wdata;
          shadow[sel][ra] = req_wdata;
        end else begin
          acc_rdata = shadow[sel][ra];
        end
      end
    end else if (age == 0) begin
      age = 1; e_rv = 1; e_rw = acc_w; e_rd = acc_w ? 8'h00 : acc_rdata;
      e_en = 0; e_mode = 1;
    end else begin
      age = -1; e_rv = 0; e_ready = 1;
    end
  endtask

  task automatic compare();
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_write", 32'(rsp_write), 32'(e_rw));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
    chk("bus_enable", 32'(bus_enable), 32'(e_en));
    chk("bus_mode", 32'(bus_mode), 32'(e_mode));
    chk("bus_address", 32'(bus_address), 32'(e_addr));
    chk("bus_data_out", 32'(bus_data_out), 32'(e_dout));
    chk("enable_onehot", 32'($countones(bus_enable) <= 1), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Present a request and wait (bounded) until the model sees it accepted.
  task automatic issue(input bit w, input logic [5:0] a, input logic [7:0] d, input bit hold);
    int guard = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    do begin
      cycle();
      guard++;
    end while (age != 0 && guard < 20);
    if (guard >= 20) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold) req_valid = 0;
  endtask

  initial begin
    int t_prev;
    logic [5:0] b2b [3];
    logic [7:0] vals [4];

    reset = 1;
    cycle();
    cycle();
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_mode", 32'(bus_mode), 32'd1);
    chk("reset_enable", 32'(bus_enable), 32'd0);
    reset = 0;
    cycle();

    // Write 0x5A to device 2 register 3, then read it back.
    issue(1, 6'h23, 8'h5A, 0);
    chk("wr_enable_lit", 32'(bus_enable), 32'h4);
    chk("wr_mode_lit", 32'(bus_mode), 32'd0);
    chk("wr_addr_lit", 32'(bus_address), 32'd3);
    cycle();
    chk("wr_rsp_lit", 32'({rsp_valid, rsp_write, rsp_rdata}), 32'h300);
    chk("wr_enable_off_lit", 32'(bus_enable), 32'h0);
    cycle();
    issue(0, 6'h23, 8'h00, 0);
    cycle();
    chk("rd_rdata_lit", 32'(rsp_rdata), 32'h5A);
    cycle();

    // Distinct values at register 7 of every device, read back in turn.
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      issue(1, {2'(i), 4'h7}, vals[i], 0);
      cycle(); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      issue(0, {2'(i), 4'h7}, 8'h00, 0);
      chk("sel_enable_lit", 32'(bus_enable), 32'(1 << i));
      cycle();
      chk("sel_rdata_lit", 32'(rsp_rdata), 32'(vals[i]));
      cycle();
    end

    // Back-to-back reads with req_valid held: accepts are three cycles apart.
    b2b[0] = 6'h00; b2b[1] = 6'h10; b2b[2] = 6'h30;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      issue(0, b2b[k], 8'h00, 1);
      if (k > 0) chk("b2b_spacing", 32'(now - t_prev), 32'd3);
      t_prev = now;
    end
    req_valid = 0;
    cycle(); cycle();

    // Reset while a read is in its bus cycle.
    issue(0, 6'h37, 8'h00, 0);
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_acc_enable_lit", 32'(bus_enable), 32'h0);
    chk("rst_acc_ready_lit", 32'(req_ready), 32'd1);
    cycle();
    chk("rst_acc_rv_lit", 32'(rsp_valid), 32'd0);
    cycle();

    // Reset in the turnaround cycle.
    issue(0, 6'h17, 8'h00, 0);
    cycle();
    chk("resp_rv_lit", 32'(rsp_valid), 32'd1);
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_resp_lit", 32'({rsp_valid, rsp_write, rsp_rdata, bus_mode, bus_enable}), 32'h10);
    cycle();

    // Reset and request together: reset wins.
    reset = 1; req_valid = 1; req_addr = 6'h21;
    cycle();
    reset = 0; req_valid = 0;
    chk("rst_req_enable_lit", 32'(bus_enable), 32'h0);
    cycle();

    // Randomized traffic including occasional resets.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 6'($urandom);
      req_wdata = 8'($urandom);
      cycle();
    end
    reset = 0; req_valid = 0;
    for (int n = 0; n < 4; n++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/device_bus_initiator.md
Name: device_bus_initiator

Overview:
- Initiator (CPU-side) end of the device register bus; turns single-access requests from the core into one bus access to one of several device register banks.
- Bus signalling: per-device enable, address, mode (1 = read, 0 = write), write data. Devices sample on the falling clock edge and drive read data while enabled in read mode.
- Decodes the upper request-address bits into a one-hot device enable.
- Captures read data and returns a one-cycle completion pulse to the core.

Parameters:
- DATA_WIDTH, 8, width of bus data and request/response data.
- ADDR_WIDTH, 4, register address width inside one device.
- DEV_SEL_WIDTH, 2, device-select bits; NUM_DEVICES = 1 << DEV_SEL_WIDTH.

Ports:
- clk  input  1  system clock; all initiator state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  initiator can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  DEV_SEL_WIDTH+ADDR_WIDTH  upper DEV_SEL_WIDTH bits select the device; lower ADDR_WIDTH bits select the register.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_write  output  1  echo of req_write for the completing access.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
- bus_address  output  ADDR_WIDTH  register address to devices.
- bus_enable  output  NUM_DEVICES  one-hot device enable.
- bus_mode  output  1  1 = read, 0 = write.
- bus_data_out  output  DATA_WIDTH  write data to devices.
- bus_data_in  input  DATA_WIDTH  resolved read-data bus from devices.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_write 0, rsp_rdata 0, bus_enable 0, bus_mode 1, bus_address 0, bus_data_out 0.
- FSM state IDLE: req_ready = 1, bus_enable = 0.
  - On rising edge with req_valid=1: register bus_address = req_addr[ADDR_WIDTH-1:0].
  - Register bus_enable = one-hot of req_addr upper bits.
  - Register bus_mode = !req_write; register bus_data_out = req_wdata (write), else hold.
  - Go to ACCESS.
- FSM state ACCESS (exactly one clk cycle): req_ready = 0; bus signals stable for the whole cycle, so the device acts on the mid-cycle falling edge.
  - On the next rising edge: capture rsp_rdata = bus_data_in (read) or 0 (write).
  - Also: rsp_valid <= 1, rsp_write <= access type, bus_enable <= 0, bus_mode <= 1. Go to RESP.
- FSM state RESP (one cycle): rsp_valid = 1, req_ready = 0, bus_enable = 0. This is the turnaround cycle that lets the device release its tristate read driver. Then go to IDLE, rsp_valid <= 0.
- rsp_rdata holds its value until the next completion. No response backpressure: the core must accept the pulse.
- Throughput: one access per 3 cycles. Latency: request accept edge to rsp_valid high = 1 cycle.
- Invariants:
  - bus_enable is never asserted in IDLE or RESP.
  - At most one bus_enable bit is ever set.
  - bus_address, bus_mode and bus_data_out change only on accept and ACCESS exit.
- req_valid outside IDLE is ignored; the core holds it until req_ready.
- Reset mid-operation: reset in ACCESS or RESP forces IDLE and all reset values on that edge; no rsp_valid is produced. A write whose falling edge already occurred has completed at the device; this is acceptable.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.

Test Plan:
- Write then read: write 0x5A to dev 2 reg 3 (req_addr 0x23) -> bus_enable=4'b0100, bus_mode=0, bus_address=3 for exactly 1 cycle; rsp_valid 1 cycle later with rsp_write=1, rsp_rdata=0. Then read 0x23 -> rsp_rdata=0x5A.
- Back-to-back: req_valid held for reads of 0x00, 0x10, 0x30 -> accepts 3 cycles apart; bus_enable low at least 1 cycle between accesses; never two bits set.
- Held request: req_valid held high through ACCESS/RESP -> exactly one access per accept; req_ready low in ACCESS and RESP.
- Device selection: all 4 devices preloaded with distinct values (0x11, 0x22, 0x33, 0x44 at reg 7); read each -> correct value, one-hot enable matches the select bits.
- Reset during ACCESS of a read -> next cycle bus_enable=0, rsp_valid never pulses, req_ready=1.
- Reset during RESP -> rsp_valid drops, all outputs at reset values.
